// File: rtl/l2_req_arbiter.sv
// Two-requester (L1I / L1D) arbiter onto the single L1-side request port of L2.
// Latency: request in IDLE cycle n -> registered L2 command from n+1; owner ready is combinational with L2 ready.
// Backpressure: winner's command/tag/index/data held frozen until L2 ready; loser waits with its request held.
// Build option: define L2_ARB_RR_EN for round-robin between I and D; otherwise fixed priority D over I.
module l2_req_arbiter #(
  parameter int TNUM   = 18,
  parameter int INUM   = 26 - TNUM,
  parameter int DWIDTH = 512
) (
  input  logic              clk,
  input  logic              nrst,
  // L1 instruction cache
  input  logic              read_L1I_L2,
  input  logic [TNUM-1:0]   tag_L1I_L2,
  input  logic [INUM-1:0]   index_L1I_L2,
  output logic              ready_L2_L1I,
  output logic [DWIDTH-1:0] read_data_L2_L1I,
  // L1 data cache
  input  logic              read_L1D_L2,
  input  logic              write_L1D_L2,
  input  logic [TNUM-1:0]   tag_L1D_L2,
  input  logic [INUM-1:0]   index_L1D_L2,
  input  logic [DWIDTH-1:0] write_data_L1D_L2,
  output logic              ready_L2_L1D,
  output logic [DWIDTH-1:0] read_data_L2_L1D,
  // L2 side
  output logic              read_L1_L2,
  output logic              write_L1_L2,
  output logic [TNUM-1:0]   tag_L1_L2,
  output logic [INUM-1:0]   index_L1_L2,
  output logic [DWIDTH-1:0] write_data,
  input  logic              ready_L2_L1,
  input  logic [DWIDTH-1:0] read_data_L2_L1,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [TNUM-1:0]     tag_q, tag_d;
  logic [INUM-1:0]     index_q, index_d;
  logic [DWIDTH-1:0]   wdata_q, wdata_d;

  logic req_i;
  logic req_d;
  logic win_i;
  logic win_d;

  assign req_i = read_L1I_L2;
  assign req_d = read_L1D_L2 | write_L1D_L2;

`ifdef L2_ARB_RR_EN
  // Pointer remembers whether the last grant went to I; reset value makes D win the first tie.
  logic last_i_q, last_i_d;

  // Tie goes to whichever side was not granted last.
  always_comb begin
    win_d = req_d & (~req_i | last_i_q);
    win_i = req_i & ~win_d;
  end

  // Pointer moves only when an IDLE-cycle grant is actually issued.
  always_comb begin
    last_i_d = last_i_q;
    if (state_q == IDLE) begin
      if (win_d) begin
        last_i_d = 1'b0;
      end else if (win_i) begin
        last_i_d = 1'b1;
      end
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_i_q <= 1'b1;
    end else begin
      last_i_q <= last_i_d;
    end
  end
`else
  // Fixed priority: any D request beats I (I may starve under sustained D traffic).
  always_comb begin
    win_d = req_d;
    win_i = req_i & ~req_d;
  end
`endif

  // Next state and next values of the frozen L2-side output registers.
  always_comb begin
    state_d = state_q;
    read_d  = read_q;
    write_d = write_q;
    tag_d   = tag_q;
    index_d = index_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        // Commands are low in IDLE; L2 ready is ignored here.
        read_d  = 1'b0;
        write_d = 1'b0;
        if (win_d) begin
          // A write-back takes precedence over a read when both D bits are set.
          read_d  = read_L1D_L2 & ~write_L1D_L2;
          write_d = write_L1D_L2;
          tag_d   = tag_L1D_L2;
          index_d = index_L1D_L2;
          wdata_d = write_data_L1D_L2;
          state_d = GRANT_D;
        end else if (win_i) begin
          read_d  = 1'b1;
          tag_d   = tag_L1I_L2;
          index_d = index_L1I_L2;
          state_d = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        // Requester inputs are ignored; only L2 completion ends the grant.
        if (ready_L2_L1) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      tag_q   <= '0;
      index_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      read_q  <= read_d;
      write_q <= write_d;
      tag_q   <= tag_d;
      index_q <= index_d;
      wdata_q <= wdata_d;
    end
  end

  // L2-side outputs come straight from registers.
  assign read_L1_L2  = read_q;
  assign write_L1_L2 = write_q;
  assign tag_L1_L2   = tag_q;
  assign index_L1_L2 = index_q;
  assign write_data  = wdata_q;
  assign busy        = (state_q != IDLE);

  // Completion is routed only to the owner; data is shared and qualified by ready.
  assign ready_L2_L1I     = ready_L2_L1 & (state_q == GRANT_I);
  assign ready_L2_L1D     = ready_L2_L1 & (state_q == GRANT_D);
  assign read_data_L2_L1I = read_data_L2_L1;
  assign read_data_L2_L1D = read_data_L2_L1;

endmodule

// File: tb/tb_l2_req_arbiter.sv
// Self-checking bench for l2_req_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (winner choice, expected command/payload, owner-only ready).
// Works for both builds; the model follows L2_ARB_RR_EN the same way the design is built.
module tb_l2_req_arbiter;
  localparam int TNUM   = 18;
  localparam int INUM   = 8;
  localparam int DWIDTH = 512;

  logic              clk = 1'b0;
  logic              nrst;
  logic              read_L1I_L2;
  logic [TNUM-1:0]   tag_L1I_L2;
  logic [INUM-1:0]   index_L1I_L2;
  logic              ready_L2_L1I;
  logic [DWIDTH-1:0] read_data_L2_L1I;
  logic              read_L1D_L2;
  logic              write_L1D_L2;
  logic [TNUM-1:0]   tag_L1D_L2;
  logic [INUM-1:0]   index_L1D_L2;
  logic [DWIDTH-1:0] write_data_L1D_L2;
  logic              ready_L2_L1D;
  logic [DWIDTH-1:0] read_data_L2_L1D;
  logic              read_L1_L2;
  logic              write_L1_L2;
  logic [TNUM-1:0]   tag_L1_L2;
  logic [INUM-1:0]   index_L1_L2;
  logic [DWIDTH-1:0] write_data;
  logic              ready_L2_L1;
  logic [DWIDTH-1:0] read_data_L2_L1;
  logic              busy;

  int n_cmp = 0;
  int n_err = 0;
  bit model_last_i;  // model: last grant went to I

  l2_req_arbiter #(.TNUM(TNUM), .INUM(INUM), .DWIDTH(DWIDTH)) dut (
    .clk(clk), .nrst(nrst),
    .read_L1I_L2(read_L1I_L2), .tag_L1I_L2(tag_L1I_L2), .index_L1I_L2(index_L1I_L2),
    .ready_L2_L1I(ready_L2_L1I), .read_data_L2_L1I(read_data_L2_L1I),
    .read_L1D_L2(read_L1D_L2), .write_L1D_L2(write_L1D_L2), .tag_L1D_L2(tag_L1D_L2),
    .index_L1D_L2(index_L1D_L2), .write_data_L1D_L2(write_data_L1D_L2),
    .ready_L2_L1D(ready_L2_L1D), .read_data_L2_L1D(read_data_L2_L1D),
    .read_L1_L2(read_L1_L2), .write_L1_L2(write_L1_L2), .tag_L1_L2(tag_L1_L2),
    .index_L1_L2(index_L1_L2), .write_data(write_data),
    .ready_L2_L1(ready_L2_L1), .read_data_L2_L1(read_data_L2_L1), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DWIDTH-1:0] rand_line();
    logic [DWIDTH-1:0] l;
    for (int w = 0; w < DWIDTH / 32; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  // Model arbitration: 0 = nobody, 1 = I, 2 = D.
  function automatic int model_winner(bit i_req, bit d_req);
    if (i_req && d_req) begin
`ifdef L2_ARB_RR_EN
      return model_last_i ? 2 : 1;
`else
      return 2;
`endif
    end
    if (d_req) return 2;
    if (i_req) return 1;
    return 0;
  endfunction

  // One full transaction starting at a negedge with the DUT idle and inputs already set.
  // Command visible for lat cycles, L2 ready during the last of them; then the idle gap is checked.
  task automatic do_txn(input int lat, input logic [DWIDTH-1:0] rdata, input bit drop);
    int own;
    logic er, ew;
    logic [TNUM-1:0] et;
    logic [INUM-1:0] ei;
    logic [DWIDTH-1:0] ed;
    own = model_winner(read_L1I_L2, read_L1D_L2 | write_L1D_L2);
    if (own == 0) return;
    if (own == 2) begin
      ew = write_L1D_L2; er = ~write_L1D_L2;
      et = tag_L1D_L2; ei = index_L1D_L2; ed = write_data_L1D_L2;
    end else begin
      ew = 1'b0; er = 1'b1; et = tag_L1I_L2; ei = index_L1I_L2; ed = '0;
    end
    model_last_i = (own == 1);
    @(posedge clk);
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      n_cmp++; if (read_L1_L2 !== er) begin n_err++; $display("FAIL cmd_read cyc%0d got %0b want %0b", j, read_L1_L2, er); end
      n_cmp++; if (write_L1_L2 !== ew) begin n_err++; $display("FAIL cmd_write cyc%0d got %0b want %0b", j, write_L1_L2, ew); end
      n_cmp++; if (tag_L1_L2 !== et) begin n_err++; $display("FAIL tag cyc%0d got %h want %h", j, tag_L1_L2, et); end
      n_cmp++; if (index_L1_L2 !== ei) begin n_err++; $display("FAIL index cyc%0d got %h want %h", j, index_L1_L2, ei); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_grant cyc%0d got %0b want 1", j, busy); end
      if (own == 2) begin
        n_cmp++; if (write_data !== ed) begin n_err++; $display("FAIL wdata cyc%0d got %h want %h", j, write_data, ed); end
      end
      n_cmp++; if ({ready_L2_L1I, ready_L2_L1D} !== 2'b00) begin n_err++; $display("FAIL early_ready cyc%0d got %b want 00", j, {ready_L2_L1I, ready_L2_L1D}); end
      // Payload changes during the grant must not leak through.
      tag_L1I_L2 = TNUM'($urandom); index_L1I_L2 = INUM'($urandom);
      tag_L1D_L2 = TNUM'($urandom); index_L1D_L2 = INUM'($urandom);
      write_data_L1D_L2 = rand_line();
      if (j == lat) begin
        ready_L2_L1 = 1'b1;
        read_data_L2_L1 = rdata;
        #1;
        n_cmp++; if (ready_L2_L1I !== (own == 1)) begin n_err++; $display("FAIL ready_I got %0b want %0b", ready_L2_L1I, own == 1); end
        n_cmp++; if (ready_L2_L1D !== (own == 2)) begin n_err++; $display("FAIL ready_D got %0b want %0b", ready_L2_L1D, own == 2); end
        if (own == 1) begin
          n_cmp++; if (read_data_L2_L1I !== rdata) begin n_err++; $display("FAIL rdata_I got %h want %h", read_data_L2_L1I, rdata); end
        end else begin
          n_cmp++; if (read_data_L2_L1D !== rdata) begin n_err++; $display("FAIL rdata_D got %h want %h", read_data_L2_L1D, rdata); end
        end
      end
    end
    @(negedge clk);
    ready_L2_L1 = 1'b0;
    if (drop) begin
      if (own == 1) read_L1I_L2 = 1'b0;
      else begin read_L1D_L2 = 1'b0; write_L1D_L2 = 1'b0; end
    end
    n_cmp++; if ({read_L1_L2, write_L1_L2} !== 2'b00) begin n_err++; $display("FAIL gap_cmd got %b want 00", {read_L1_L2, write_L1_L2}); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL gap_busy got %0b want 0", busy); end
  endtask

  task automatic check_all_zero(input string name);
    n_cmp++;
    if ({read_L1_L2, write_L1_L2, busy, ready_L2_L1I, ready_L2_L1D} !== 5'b0 || tag_L1_L2 !== '0 ||
        index_L1_L2 !== '0 || write_data !== '0) begin
      n_err++;
      $display("FAIL %s got rd%0b wr%0b busy%0b rdyI%0b rdyD%0b tag%h idx%h want all 0", name,
               read_L1_L2, write_L1_L2, busy, ready_L2_L1I, ready_L2_L1D, tag_L1_L2, index_L1_L2);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    model_last_i = 1'b1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    read_L1I_L2 = 0; tag_L1I_L2 = '0; index_L1I_L2 = '0;
    read_L1D_L2 = 0; write_L1D_L2 = 0; tag_L1D_L2 = '0; index_L1D_L2 = '0;
    write_data_L1D_L2 = '0; ready_L2_L1 = 0; read_data_L2_L1 = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    nrst = 1'b1;
    model_last_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_i();
    read_L1I_L2 = 1'b1; tag_L1I_L2 = 18'h2A5F1; index_L1I_L2 = 8'h17;
    do_txn(3, {16{32'hDEADBEEF}}, 1'b1);
  endtask

  task automatic test_d_write();
    write_L1D_L2 = 1'b1; tag_L1D_L2 = TNUM'($urandom); index_L1D_L2 = INUM'($urandom);
    write_data_L1D_L2 = {64{8'hA5}};
    do_txn(4, rand_line(), 1'b1);
  endtask

  task automatic test_d_rdwr();
    read_L1D_L2 = 1'b1; write_L1D_L2 = 1'b1; tag_L1D_L2 = TNUM'($urandom);
    write_data_L1D_L2 = rand_line();
    do_txn(2, rand_line(), 1'b1);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    read_L1I_L2 = 1'b1; read_L1D_L2 = 1'b1;
    for (int k = 0; k < 4; k++) do_txn(1 + k, rand_line(), 1'b0);
    read_L1I_L2 = 1'b0; read_L1D_L2 = 1'b0; write_L1D_L2 = 1'b0;
  endtask

  task automatic test_spurious_ready();
    @(negedge clk);
    ready_L2_L1 = 1'b1; read_data_L2_L1 = rand_line();
    #1;
    n_cmp++; if ({ready_L2_L1I, ready_L2_L1D} !== 2'b00) begin n_err++; $display("FAIL idle_ready got %b want 00", {ready_L2_L1I, ready_L2_L1D}); end
    @(negedge clk);
    ready_L2_L1 = 1'b0;
    n_cmp++; if ({busy, read_L1_L2, write_L1_L2} !== 3'b000) begin n_err++; $display("FAIL idle_state got %b want 000", {busy, read_L1_L2, write_L1_L2}); end
  endtask

  task automatic test_reset_mid_grant();
    write_L1D_L2 = 1'b1; write_data_L1D_L2 = rand_line(); tag_L1D_L2 = TNUM'($urandom);
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (write_L1_L2 !== 1'b1) begin n_err++; $display("FAIL rst_pre_grant got %0b want 1", write_L1_L2); end
    nrst = 1'b0;
    ready_L2_L1 = 1'b1;
    #1;
    check_all_zero("reset_mid_grant");
    @(negedge clk);
    nrst = 1'b1; ready_L2_L1 = 1'b0;
    model_last_i = 1'b1;
    do_txn(2, rand_line(), 1'b1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      if (!read_L1I_L2 && $urandom_range(0, 1) == 1) begin
        read_L1I_L2 = 1'b1; tag_L1I_L2 = TNUM'($urandom); index_L1I_L2 = INUM'($urandom);
      end
      if (!(read_L1D_L2 || write_L1D_L2) && $urandom_range(0, 1) == 1) begin
        read_L1D_L2 = 1'($urandom); write_L1D_L2 = 1'($urandom);
        if (!read_L1D_L2 && !write_L1D_L2) read_L1D_L2 = 1'b1;
        tag_L1D_L2 = TNUM'($urandom); index_L1D_L2 = INUM'($urandom);
        write_data_L1D_L2 = rand_line();
      end
      if (!read_L1I_L2 && !read_L1D_L2 && !write_L1D_L2) test_spurious_ready();
      else do_txn($urandom_range(1, 4), rand_line(), $urandom_range(0, 3) != 0);
    end
    read_L1I_L2 = 1'b0; read_L1D_L2 = 1'b0; write_L1D_L2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_d_write();
    test_d_rdwr();
    test_simultaneous();
    test_spurious_ready();
    test_reset_mid_grant();
    test_random();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
